pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter / fetch-address sequencer for the MC14500B system.
- Drives the address of the program memory (a RAM instance) directly upstream of instruction decode.
- Advances the PC each cycle and handles the ICU JMP and RTN flag outputs, including a hardware return stack for subroutine calls.
- Provides a halt hold for the FLGF-driven stop.

Parameters:
ADDR_WIDTH, 8, width of program address / PC
STACK_DEPTH, 4, number of return-address entries (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
halt  input  1  hold PC and stack this cycle (FLGF)
jmp  input  1  ICU JMP flag: load PC from target
call  input  1  qualifies jmp as subroutine call (push return address)
rtn  input  1  ICU RTN flag: pop PC from return stack
target  input  ADDR_WIDTH  jump target (instruction address field)
address  output  ADDR_WIDTH  current PC, drives program memory address
stack_depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
overflow  output  1  sticky: push attempted while stack full
underflow  output  1  sticky: pop attempted while stack empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - address = 0, stack_depth = 0, overflow = 0, underflow = 0.
  - Stack contents are don't-care.
- address is the registered PC with no combinational path from inputs. A change on jmp/rtn/target is visible on address exactly one cycle later.
- Per rising edge, next PC is chosen by priority halt > rtn > jmp > increment:
  - halt=1: PC, stack and flags unchanged. All other inputs ignored.
  - rtn=1: if depth>0, PC <= top entry and depth decrements. If depth==0, underflow <= 1 and PC <= PC+1.
  - jmp=1 (rtn=0): PC <= target.
    - If call=1 and depth<STACK_DEPTH: push PC+1 and depth increments.
    - If call=1 and depth==STACK_DEPTH: overflow <= 1, no push, jump still taken.
  - Otherwise: PC <= PC+1.
- jmp and rtn in the same cycle: rtn wins and jmp/call are ignored, with no push.
- call without jmp is ignored.
- Arithmetic: PC+1 is modulo 2^ADDR_WIDTH. The all-ones address wraps to 0, both for increment and for the pushed return address.
- overflow/underflow are sticky until reset. They never block sequencing.
- Reset asserted mid-operation clears everything immediately (async). The first post-reset edge increments from 0 to 1 unless halt/jmp/rtn are asserted.
- Stack is LIFO. Top entry = last pushed. Nested calls return in reverse order.

Decomposition:
- Package mc_pkg holds:
  - DEFAULT_ADDR_WIDTH and DEFAULT_STACK_DEPTH constants.
  - Enum pc_src_t {PC_HOLD, PC_RET, PC_JMP, PC_INC} used by the next-PC mux.
- Sub-module pc_return_stack, parameterised by ADDR_WIDTH and STACK_DEPTH:
  - Ports: push, pop, push_data, top, depth, full, empty.
  - Same clock/reset, array storage plus a depth counter.
  - Never pushes when full and never pops when empty.
- pc_sequencer contains the priority logic, the PC register and the sticky flags.

Test Plan:
- Reset then 5 idle cycles -> address 0,1,2,3,4,5. Assert rst_n=0 mid-run, away from a clock edge -> address=0 immediately.
- PC reaches 8'hFF, no inputs -> next address 8'h00, no flags set.
- At PC=8'h10: jmp=1, call=1, target=8'h40 -> address=8'h40, depth=1. Later rtn=1 -> address=8'h11, depth=0.
- Nested calls from 8'h02, 8'h41, 8'h81, 8'hC1, 8'hE0 (STACK_DEPTH=4):
  - First four push 8'h03, 8'h42, 8'h82, 8'hC2.
  - Fifth sets overflow=1, still jumps, depth stays 4.
  - Four rtn -> 8'hC2, 8'h82, 8'h42, 8'h03.
- rtn with depth 0 at PC=8'h20 -> underflow=1, address=8'h21. jmp+rtn together with depth 1, top 8'h33 -> address=8'h33, no push.
- halt=1 for 3 cycles with jmp/rtn/call toggling -> address, depth and flags frozen. Release -> sequencing resumes from the held PC+1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and types for the MC14500B fetch path.
package mc_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH  = 8;
   localparam int unsigned DEFAULT_STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_RET,
      PC_JMP,
      PC_INC
   } pc_src_t;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with a depth counter; guards against push-when-full
// and pop-when-empty.
module pc_return_stack
   import mc_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic [ADDR_WIDTH-1:0]                push_data,
   output logic [ADDR_WIDTH-1:0]                top,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
   output logic                                 full,
   output logic                                 empty
);

   localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

   logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [DW-1:0]         depth_q, depth_d;
   logic                  do_push, do_pop;

   assign full    = (depth_q == DW'(STACK_DEPTH));
   assign empty   = (depth_q == '0);
   assign do_push = push && !full;
   // Push wins if both are requested; the sequencer never issues both.
   assign do_pop  = pop && !empty && !push;

   always_comb begin
      depth_d = depth_q;
      if (do_push) begin
         depth_d = depth_q + 1'b1;
      end else if (do_pop) begin
         depth_d = depth_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Storage is not reset; entries above depth are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
         if (do_push && depth_q == DW'(i)) begin
            mem_q[i] <= push_data;
         end
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
         if (depth_q == DW'(i + 1)) begin
            top = mem_q[i];
         end
      end
   end

   assign depth = depth_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the MC14500B: increment, JMP/call, RTN via return stack,
// and FLGF halt hold, with sticky overflow/underflow flags.
module pc_sequencer
   import mc_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 halt,
   input  logic                                 jmp,
   input  logic                                 call,
   input  logic                                 rtn,
   input  logic [ADDR_WIDTH-1:0]                target,
   output logic [ADDR_WIDTH-1:0]                address,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_depth,
   output logic                                 overflow,
   output logic                                 underflow
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, stk_top;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  push, pop, stk_full, stk_empty;
   pc_src_t               src;

   assign pc_inc = pc_q + 1'b1;

   // Priority: halt > rtn > jmp > increment.
   always_comb begin
      src   = PC_INC;
      push  = 1'b0;
      pop   = 1'b0;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (halt) begin
         src = PC_HOLD;
      end else if (rtn) begin
         if (!stk_empty) begin
            src = PC_RET;
            pop = 1'b1;
         end else begin
            unf_d = 1'b1;
         end
      end else if (jmp) begin
         src = PC_JMP;
         if (call) begin
            if (!stk_full) begin
               push = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pc_d = pc_inc;
      unique case (src)
         PC_HOLD: pc_d = pc_q;
         PC_RET:  pc_d = stk_top;
         PC_JMP:  pc_d = target;
         PC_INC:  pc_d = pc_inc;
         default: pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   pc_return_stack #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (stk_top),
      .depth     (stack_depth),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   assign address   = pc_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       halt = 1'b0, jmp = 1'b0, call = 1'b0, rtn = 1'b0;
   logic [7:0] target = '0;
   logic [7:0] address;
   logic [2:0] stack_depth;
   logic       overflow, underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model
   int m_pc;
   int m_stack[$];
   bit m_ovf, m_unf;

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_WIDTH  (8),
      .STACK_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .halt        (halt),
      .jmp         (jmp),
      .call        (call),
      .rtn         (rtn),
      .target      (target),
      .address     (address),
      .stack_depth (stack_depth),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   function automatic void model_reset();
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
   endfunction

   function automatic void model_step(bit h, bit j, bit c, bit r, int t);
      if (h) return;
      if (r) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_unf = 1;
            m_pc  = (m_pc + 1) % 256;
         end
      end else if (j) begin
         if (c) begin
            if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 256);
            else m_ovf = 1;
         end
         m_pc = t;
      end else begin
         m_pc = (m_pc + 1) % 256;
      end
   endfunction

   // Drive one cycle's inputs, let the edge happen, advance the model, settle.
   task automatic cycle(input bit h, input bit j, input bit c, input bit r,
                        input logic [7:0] t);
      halt = h; jmp = j; call = c; rtn = r; target = t;
      @(posedge clk);
      model_step(h, j, c, r, int'(t));
      #1;
      halt = 0; jmp = 0; call = 0; rtn = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (address !== 8'h00 || stack_depth !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got addr=%h depth=%0d ovf=%b unf=%b want 00/0/0/0",
                  address, stack_depth, overflow, underflow);
      end
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         cycle(0, 0, 0, 0, 8'h00);
         n_checks++;
         if (address !== 8'(i)) begin
            n_fail++;
            $display("FAIL idle_count[%0d]: got %h want %h", i, address, 8'(i));
         end
      end
      // Leave sticky state behind so the async reset has something to clear.
      cycle(0, 0, 0, 1, 8'h00);
      cycle(0, 1, 1, 0, 8'h90);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (address !== 8'h00 || stack_depth !== 3'd0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got addr=%h depth=%0d unf=%b want 00/0/0",
                  address, stack_depth, underflow);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0, 0, 8'h00);
      n_checks++;
      if (address !== 8'h01) begin
         n_fail++;
         $display("FAIL post_reset_inc: got %h want 01", address);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(0, 1, 0, 0, 8'hFE);
      cycle(0, 0, 0, 0, 8'h00);
      n_checks++;
      if (address !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_pre: got %h want ff", address);
      end
      cycle(0, 0, 0, 0, 8'h00);
      n_checks++;
      if (address !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap: got addr=%h ovf=%b unf=%b want 00/0/0", address, overflow, underflow);
      end
   endtask

   task automatic test_call_return();
      do_reset();
      cycle(0, 1, 0, 0, 8'h10);
      cycle(0, 1, 1, 0, 8'h40);
      n_checks++;
      if (address !== 8'h40 || stack_depth !== 3'd1) begin
         n_fail++;
         $display("FAIL call: got addr=%h depth=%0d want 40/1", address, stack_depth);
      end
      cycle(0, 0, 0, 0, 8'h00);
      cycle(0, 0, 1, 0, 8'h55); // call without jmp is ignored
      n_checks++;
      if (address !== 8'h42 || stack_depth !== 3'd1) begin
         n_fail++;
         $display("FAIL call_no_jmp: got addr=%h depth=%0d want 42/1", address, stack_depth);
      end
      cycle(0, 0, 0, 1, 8'h00);
      n_checks++;
      if (address !== 8'h11 || stack_depth !== 3'd0) begin
         n_fail++;
         $display("FAIL return: got addr=%h depth=%0d want 11/0", address, stack_depth);
      end
   endtask

   task automatic test_nested();
      logic [7:0] tgt[5];
      logic [7:0] ret[4];
      tgt = '{8'h41, 8'h81, 8'hC1, 8'hE0, 8'hF0};
      ret = '{8'hC2, 8'h82, 8'h42, 8'h03};
      do_reset();
      cycle(0, 1, 0, 0, 8'h02);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 0, tgt[i]);
         n_checks++;
         if (address !== tgt[i] || stack_depth !== 3'(i < 4 ? i + 1 : 4) ||
             overflow !== (i == 4)) begin
            n_fail++;
            $display("FAIL nest_call[%0d]: got addr=%h depth=%0d ovf=%b want %h/%0d/%b",
                     i, address, stack_depth, overflow, tgt[i], (i < 4 ? i + 1 : 4), (i == 4));
         end
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 1, 8'h00);
         n_checks++;
         if (address !== ret[i] || stack_depth !== 3'(3 - i) || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL nest_ret[%0d]: got addr=%h depth=%0d ovf=%b want %h/%0d/1",
                     i, address, stack_depth, overflow, ret[i], 3 - i);
         end
      end
   endtask

   task automatic test_underflow_jmp_rtn();
      do_reset();
      cycle(0, 1, 0, 0, 8'h20);
      cycle(0, 0, 0, 1, 8'h00);
      n_checks++;
      if (address !== 8'h21 || underflow !== 1'b1 || stack_depth !== 3'd0) begin
         n_fail++;
         $display("FAIL underflow: got addr=%h unf=%b depth=%0d want 21/1/0",
                  address, underflow, stack_depth);
      end
      cycle(0, 1, 0, 0, 8'h32);
      cycle(0, 1, 1, 0, 8'h50);
      cycle(0, 1, 1, 1, 8'h77);
      n_checks++;
      if (address !== 8'h33 || stack_depth !== 3'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL jmp_rtn: got addr=%h depth=%0d ovf=%b want 33/0/0",
                  address, stack_depth, overflow);
      end
   endtask

   task automatic test_halt();
      do_reset();
      cycle(0, 1, 0, 0, 8'h60);
      cycle(0, 1, 1, 0, 8'h70);
      cycle(0, 0, 0, 1, 8'h00); // depth 0 -> underflow off path? no: returns to 61
      cycle(0, 0, 0, 1, 8'h00); // now empty: underflow set, pc 62
      cycle(0, 1, 1, 0, 8'hA0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
         n_checks++;
         if (address !== 8'hA0 || stack_depth !== 3'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL halt[%0d]: got addr=%h depth=%0d unf=%b ovf=%b want a0/1/1/0",
                     i, address, stack_depth, underflow, overflow);
         end
      end
      cycle(0, 0, 0, 0, 8'h00);
      n_checks++;
      if (address !== 8'hA1) begin
         n_fail++;
         $display("FAIL halt_release: got %h want a1", address);
      end
   endtask

   task automatic test_random();
      bit h, j, c, r;
      logic [7:0] t;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         h = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 5) == 0);
         j = ($urandom_range(0, 3) == 0);
         c = 1'($urandom);
         t = 8'($urandom);
         cycle(h, j, c, r, t);
         n_checks++;
         if (address !== 8'(m_pc) || stack_depth !== 3'(m_stack.size()) ||
             overflow !== m_ovf || underflow !== m_unf) begin
            n_fail++;
            $display("FAIL random[%0d]: got addr=%h depth=%0d ovf=%b unf=%b want %h/%0d/%b/%b",
                     i, address, stack_depth, overflow, underflow,
                     8'(m_pc), m_stack.size(), m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_wrap();
      test_call_return();
      test_nested();
      test_underflow_jmp_rtn();
      test_halt();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
